// File: rtl/bombe_search.sv
// ---------------------------------------------------------------------------
// bombe_search
//   Brute-force key search for a shifting Caesar cipher. The user loads
//   CRIB_LEN (ciphertext, known-plaintext) character pairs, one per rising
//   edge of key_press. After go, the block tries keys k = 0..25, one key per
//   clock. Position i decodes with shift (k + i*STEP) mod 26. The result is
//   held in DONE until restart.
//
// Parameters
//   CRIB_LEN  number of character pairs, 1..8
//   STEP      rotor advance per character position, 0..25
//
// Ports
//   clk          single clock
//   reset        asynchronous, active-high; clears all state
//   char_in      ASCII ciphertext character
//   crib_in      ASCII plaintext crib character, paired with char_in
//   key_press    user key level; a pair is stored on its rising edge
//   go           starts the search once all pairs are loaded
//   restart      in DONE, returns to LOAD and clears the stored crib
//   bombe_out    found key 0..25, or 8'hFF when no key matched
//   done         high while in DONE
//   found        high in DONE when a key matched
//   busy         high while in SEARCH
//   loaded       number of pairs stored so far
//   match_count  (BOMBE_MATCH_COUNT_EN only) number of matching keys
//   fsm_state    debug view of the state register (LOAD=0, SEARCH=1, DONE=2)
//
// Configuration
//   BOMBE_MATCH_COUNT_EN  when defined, all 26 keys are always tried.
//                         bombe_out reports the lowest matching key and
//                         match_count reports how many keys matched.
//
// Handshake: go is a single-cycle request. It is accepted only in LOAD with
// loaded == CRIB_LEN, and busy rises on the same edge. done/found/bombe_out
// form a level result that stays held until restart is seen in DONE.
// ---------------------------------------------------------------------------
module bombe_search #(
  parameter int CRIB_LEN = 3,
  parameter int STEP     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char_in,
  input  logic [7:0] crib_in,
  input  logic       key_press,
  input  logic       go,
  input  logic       restart,
  output logic [7:0] bombe_out,
  output logic       done,
  output logic       found,
  output logic       busy,
  output logic [3:0] loaded,
`ifdef BOMBE_MATCH_COUNT_EN
  output logic [4:0] match_count,
`endif
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] FULL     = 4'(CRIB_LEN);
  localparam logic [4:0] LAST_KEY = 5'd25;
  localparam logic [7:0] NO_KEY   = 8'hFF;

  state_t      state_q, state_d;
  logic        key_press_q;
  logic        rise;
  logic [4:0]  k_q;
  logic [7:0]  cipher_q [CRIB_LEN];
  logic [7:0]  plain_q  [CRIB_LEN];
  logic [CRIB_LEN-1:0] pos_match;
  logic        key_match;

  assign rise = key_press & ~key_press_q;

  // Per-position decode for the key currently under test. The per-position
  // offset i*STEP mod 26 is an elaboration-time constant. The sum k+offset
  // is at most 50, so a single conditional subtract reduces it mod 26.
  for (genvar i = 0; i < CRIB_LEN; i++) begin : g_pos
    localparam logic [7:0] OFF = 8'((i * STEP) % 26);
    logic [7:0] sum8;
    logic [7:0] shift8;
    logic [7:0] c8;
    logic [7:0] dec8;
    logic       is_letter;
    logic       hit;

    always_comb begin
      sum8      = {3'b000, k_q} + OFF;
      shift8    = (sum8 >= 8'd26) ? (sum8 - 8'd26) : sum8;
      is_letter = (cipher_q[i] >= 8'd65) && (cipher_q[i] <= 8'd90);
      c8        = cipher_q[i] - 8'd65;
      // Borrow-free modular subtract: add 26 first when c < shift.
      dec8      = (c8 >= shift8) ? (c8 - shift8 + 8'd65)
                                 : (c8 + 8'd26 - shift8 + 8'd65);
      // A decoded letter can never equal a non-letter crib byte, so only
      // the cipher side needs an explicit range check.
      hit       = is_letter && (dec8 == plain_q[i]);
    end

    assign pos_match[i] = hit;
  end

  assign key_match = &pos_match;

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: begin
        // A rise on the same cycle can only coexist with loaded < FULL, so
        // a load always wins over go here.
        if (go && (loaded == FULL)) state_d = S_SEARCH;
      end
      S_SEARCH: begin
`ifdef BOMBE_MATCH_COUNT_EN
        if (k_q == LAST_KEY) state_d = S_DONE;
`else
        if (key_match || (k_q == LAST_KEY)) state_d = S_DONE;
`endif
      end
      S_DONE: begin
        if (restart) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign done      = (state_q == S_DONE);
  assign busy      = (state_q == S_SEARCH);
  assign fsm_state = state_q;

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_press_q <= 1'b0;
      loaded      <= 4'd0;
      k_q         <= 5'd0;
      bombe_out   <= NO_KEY;
      found       <= 1'b0;
`ifdef BOMBE_MATCH_COUNT_EN
      match_count <= 5'd0;
`endif
      for (int i = 0; i < CRIB_LEN; i++) begin
        cipher_q[i] <= 8'd0;
        plain_q[i]  <= 8'd0;
      end
    end else begin
      key_press_q <= key_press;
      case (state_q)
        S_LOAD: begin
          if (rise && (loaded < FULL)) begin
            for (int i = 0; i < CRIB_LEN; i++) begin
              if (loaded == 4'(i)) begin
                cipher_q[i] <= char_in;
                plain_q[i]  <= crib_in;
              end
            end
            loaded <= loaded + 4'd1;
          end
          if (go && (loaded == FULL)) begin
            k_q       <= 5'd0;
            bombe_out <= NO_KEY;
            found     <= 1'b0;
`ifdef BOMBE_MATCH_COUNT_EN
            match_count <= 5'd0;
`endif
          end
        end
        S_SEARCH: begin
`ifdef BOMBE_MATCH_COUNT_EN
          // Keys are tried in ascending order, so the first hit is the
          // lowest one.
          if (key_match) begin
            match_count <= match_count + 5'd1;
            if (!found) begin
              found     <= 1'b1;
              bombe_out <= {3'b000, k_q};
            end
          end
          if (k_q != LAST_KEY) k_q <= k_q + 5'd1;
`else
          if (key_match) begin
            found     <= 1'b1;
            bombe_out <= {3'b000, k_q};
          end else if (k_q == LAST_KEY) begin
            found     <= 1'b0;
            bombe_out <= NO_KEY;
          end else begin
            k_q <= k_q + 5'd1;
          end
`endif
        end
        S_DONE: begin
          if (restart) begin
            loaded    <= 4'd0;
            k_q       <= 5'd0;
            bombe_out <= NO_KEY;
            found     <= 1'b0;
`ifdef BOMBE_MATCH_COUNT_EN
            match_count <= 5'd0;
`endif
            for (int i = 0; i < CRIB_LEN; i++) begin
              cipher_q[i] <= 8'd0;
              plain_q[i]  <= 8'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bombe_search.sv
// ---------------------------------------------------------------------------
// tb_bombe_search
//   Directed bench for bombe_search. Two instances are used: dut1 with the
//   default CRIB_LEN=3/STEP=1, and dut2 with CRIB_LEN=2/STEP=0. For each
//   search the driver pushes {latency, found, key, match_count} into the
//   instance's queue. A monitor per instance pops and compares when done
//   rises. Latency is the number of cycles busy was high.
// ---------------------------------------------------------------------------
module tb_bombe_search;

  localparam int W = 22;  // {lat[7:0], found, key[7:0], mc[4:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] char_in, crib_in;
  logic       kp, go_s, rs_s, sel;

  logic key1, key2, go1, go2, rs1, rs2;
  assign key1 = kp   & ~sel;
  assign key2 = kp   &  sel;
  assign go1  = go_s & ~sel;
  assign go2  = go_s &  sel;
  assign rs1  = rs_s & ~sel;
  assign rs2  = rs_s &  sel;

  logic [7:0] bout1, bout2;
  logic       done1, done2, found1, found2, busy1, busy2;
  logic [3:0] loaded1, loaded2;
  logic [4:0] mc1, mc2;
  logic [1:0] st1, st2;

  bombe_search #(.CRIB_LEN(3), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .char_in(char_in), .crib_in(crib_in),
    .key_press(key1), .go(go1), .restart(rs1), .bombe_out(bout1),
    .done(done1), .found(found1), .busy(busy1), .loaded(loaded1),
`ifdef BOMBE_MATCH_COUNT_EN
    .match_count(mc1),
`endif
    .fsm_state(st1)
  );

  bombe_search #(.CRIB_LEN(2), .STEP(0)) dut2 (
    .clk(clk), .reset(reset), .char_in(char_in), .crib_in(crib_in),
    .key_press(key2), .go(go2), .restart(rs2), .bombe_out(bout2),
    .done(done2), .found(found2), .busy(busy2), .loaded(loaded2),
`ifdef BOMBE_MATCH_COUNT_EN
    .match_count(mc2),
`endif
    .fsm_state(st2)
  );

`ifndef BOMBE_MATCH_COUNT_EN
  assign mc1 = 5'd0;
  assign mc2 = 5'd0;
`endif

  logic       done_s, busy_s;
  logic [7:0] bout_s;
  logic [3:0] loaded_s;
  assign done_s   = sel ? done2   : done1;
  assign busy_s   = sel ? busy2   : busy1;
  assign bout_s   = sel ? bout2   : bout1;
  assign loaded_s = sel ? loaded2 : loaded1;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] make_exp(input logic f, input logic [7:0] key,
                                            input logic [4:0] mc);
    logic [7:0] lat;
`ifdef BOMBE_MATCH_COUNT_EN
    lat = 8'd26;
`else
    lat = f ? (key + 8'd1) : 8'd26;
`endif
    return {lat, f, key, mc};
  endfunction

  logic       done1_q = 1'b0, done2_q = 1'b0;
  logic [7:0] lat1 = 8'd0, lat2 = 8'd0;

  always @(negedge clk) begin
    if (reset) begin
      lat1    <= 8'd0;
      done1_q <= 1'b0;
    end else begin
      done1_q <= done1;
      if (done1 && !done1_q) begin
        lat1 <= 8'd0;
        if (exp_q1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL dut1 unexpected done: got bombe_out %0h expected no result", bout1);
        end else begin
          check("dut1 latency",   lat1,   exp_q1[0][21:14]);
          check("dut1 found",     found1, exp_q1[0][13]);
          check("dut1 bombe_out", bout1,  exp_q1[0][12:5]);
`ifdef BOMBE_MATCH_COUNT_EN
          check("dut1 match_count", mc1,  exp_q1[0][4:0]);
`endif
          exp_q1.delete(0);
        end
      end else if (busy1) begin
        lat1 <= lat1 + 8'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      lat2    <= 8'd0;
      done2_q <= 1'b0;
    end else begin
      done2_q <= done2;
      if (done2 && !done2_q) begin
        lat2 <= 8'd0;
        if (exp_q2.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL dut2 unexpected done: got bombe_out %0h expected no result", bout2);
        end else begin
          check("dut2 latency",   lat2,   exp_q2[0][21:14]);
          check("dut2 found",     found2, exp_q2[0][13]);
          check("dut2 bombe_out", bout2,  exp_q2[0][12:5]);
`ifdef BOMBE_MATCH_COUNT_EN
          check("dut2 match_count", mc2,  exp_q2[0][4:0]);
`endif
          exp_q2.delete(0);
        end
      end else if (busy2) begin
        lat2 <= lat2 + 8'd1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_pair(input logic [7:0] c, input logic [7:0] p);
    @(negedge clk);
    char_in = c;
    crib_in = p;
    kp      = 1'b1;
    @(negedge clk);
    kp      = 1'b0;
  endtask

  task automatic pulse_go();
    @(negedge clk);
    go_s = 1'b1;
    @(negedge clk);
    go_s = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    rs_s = 1'b1;
    @(negedge clk);
    rs_s = 1'b0;
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_s) begin
        got = 1'b1;
        break;
      end
    end
    check("done within cycle budget", got, 1'b1);
  endtask

  task automatic start_search(input logic f, input logic [7:0] key, input logic [4:0] mc);
    if (sel) exp_q2.push_back(make_exp(f, key, mc));
    else     exp_q1.push_back(make_exp(f, key, mc));
    pulse_go();
    wait_done();
  endtask

  task automatic finish_search();
    pulse_restart();
    check("restart loaded",    loaded_s, 4'd0);
    check("restart done",      done_s,   1'b0);
    check("restart bombe_out", bout_s,   8'hFF);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; char_in = 8'd0; crib_in = 8'd0;
    kp = 1'b0; go_s = 1'b0; rs_s = 1'b0; sel = 1'b0;
    repeat (2) @(negedge clk);
    check("reset bombe_out", bout1,   8'hFF);
    check("reset done",      done1,   1'b0);
    check("reset found",     found1,  1'b0);
    check("reset busy",      busy1,   1'b0);
    check("reset loaded",    loaded1, 4'd0);
    check("reset fsm_state", st1,     2'd0);
    check("reset dut2 bombe_out", bout2, 8'hFF);
    reset = 1'b0;

    // D-3, F-4, H-5 decode to A, B, C: key 3.
    load_pair("D", "A"); load_pair("F", "B"); load_pair("H", "C");
    start_search(1'b1, 8'd3, 5'd1);
    // go and key_press have no effect while the result is held.
    @(negedge clk); go_s = 1'b1; kp = 1'b1; char_in = "X"; crib_in = "Y";
    @(negedge clk); go_s = 1'b0; kp = 1'b0;
    @(negedge clk);
    check("held done",      done1,   1'b1);
    check("held busy",      busy1,   1'b0);
    check("held loaded",    loaded1, 4'd3);
    check("held bombe_out", bout1,   8'd3);
    finish_search();

    // Lowest key: A-0, C-1, E-2 -> A, B, C.
    load_pair("A", "A"); load_pair("C", "B"); load_pair("E", "C");
    start_search(1'b1, 8'd0, 5'd1);
    finish_search();

    // Highest key: Z-25, B-0, D-1 -> A, B, C.
    load_pair("Z", "A"); load_pair("B", "B"); load_pair("D", "C");
    start_search(1'b1, 8'd25, 5'd1);
    finish_search();

    // A,A,A against A,B,C needs k=0 and k=24 at once: no key.
    load_pair("A", "A"); load_pair("A", "B"); load_pair("A", "C");
    start_search(1'b0, 8'hFF, 5'd0);
    finish_search();

    // With a step of 1, the identity crib A,B,C decodes at no key.
    load_pair("A", "A"); load_pair("B", "B"); load_pair("C", "C");
    start_search(1'b0, 8'hFF, 5'd0);
    finish_search();

    // Lower-case cipher byte never matches, even though positions 1..2 do at k=0.
    load_pair("a", "A"); load_pair("C", "B"); load_pair("E", "C");
    start_search(1'b0, 8'hFF, 5'd0);
    finish_search();

    // Non-letter crib byte never matches.
    load_pair("A", "1"); load_pair("C", "B"); load_pair("E", "C");
    start_search(1'b0, 8'hFF, 5'd0);
    finish_search();

    // Partial load: go ignored, restart ignored outside DONE.
    load_pair("D", "A"); load_pair("F", "B");
    check("partial loaded", loaded1, 4'd2);
    pulse_go();
    check("partial go busy", busy1, 1'b0);
    check("partial go done", done1, 1'b0);
    pulse_restart();
    check("restart in LOAD ignored", loaded1, 4'd2);
    // Held key with go on the same cycle as the last load: one load, no start.
    @(negedge clk); char_in = "H"; crib_in = "C"; kp = 1'b1; go_s = 1'b1;
    @(negedge clk); go_s = 1'b0;
    repeat (4) @(negedge clk);
    kp = 1'b0;
    check("held key single load", loaded1, 4'd3);
    check("go with last load busy", busy1, 1'b0);
    start_search(1'b1, 8'd3, 5'd1);
    finish_search();

    // Reset in the middle of a search at k=10.
    load_pair("A", "A"); load_pair("A", "B"); load_pair("A", "C");
    pulse_go();
    repeat (10) @(negedge clk);
    check("mid search busy", busy1, 1'b1);
    reset = 1'b1;
    #1;
    check("abort busy",      busy1,   1'b0);
    check("abort done",      done1,   1'b0);
    check("abort loaded",    loaded1, 4'd0);
    check("abort bombe_out", bout1,   8'hFF);
    @(negedge clk);
    reset = 1'b0;

    // dut2: CRIB_LEN=2, STEP=0.
    sel = 1'b1;
    load_pair("C", "A"); load_pair("D", "B");
    start_search(1'b1, 8'd2, 5'd1);
    finish_search();
    load_pair("A", "A"); load_pair("A", "A");
    start_search(1'b1, 8'd0, 5'd1);
    finish_search();
    load_pair("A", "A"); load_pair("B", "B");
    start_search(1'b1, 8'd0, 5'd1);
    finish_search();

    repeat (3) @(negedge clk);
    check("dut1 pending results", exp_q1.size(), 0);
    check("dut2 pending results", exp_q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
